// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a valid/ready handshake and a two-entry skid buffer.
// in_ready and out_valid decode registered state only; ret_addr and bank are computed at capture.
module if_id_skid_reg #(
  parameter int PC_W       = 32,
  parameter int INSN_W     = 32,
  parameter int SIDE_W     = 36,
  parameter int INSN_BYTES = 4,
  parameter int BANK_LSB   = 3,
  parameter int BANK_W     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INSN_W-1:0] in_insn,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INSN_W-1:0] out_insn,
  output logic [SIDE_W-1:0] out_side,
  output logic [PC_W-1:0]   out_ret_addr,
  output logic [BANK_W-1:0] out_bank,
  output logic [1:0]        occupancy
);

  localparam int              E_W   = PC_W + INSN_W + SIDE_W + PC_W + BANK_W;
  localparam logic [PC_W-1:0] L_INC = PC_W'(INSN_BYTES);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL1 = 2'd1,
    S_FULL2 = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_HOLD      = 2'd0,
    OP_LOAD_IN   = 2'd1,
    OP_LOAD_SKID = 2'd2,
    OP_CLEAR     = 2'd3
  } op_t;

  generate
    if (BANK_LSB + BANK_W > PC_W) begin : g_bank_range_bad
      $error("if_id_skid_reg: BANK_LSB + BANK_W exceeds PC_W");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_nxt;
  op_t              w_main_op;
  op_t              w_skid_op;
  logic [E_W-1:0]   r_main;
  logic [E_W-1:0]   r_skid;
  logic [E_W-1:0]   w_in_entry;
  logic [PC_W-1:0]  w_in_ret;
  logic             w_acc;
  logic             w_emit;

  assign w_in_ret   = in_pc + L_INC;
  assign w_in_entry = {in_pc, in_insn, in_side, w_in_ret, in_pc[BANK_LSB +: BANK_W]};

  assign in_ready  = (r_state != S_FULL2);
  assign out_valid = (r_state != S_EMPTY);
  assign occupancy = r_state;
  assign w_acc     = in_valid && in_ready;
  assign w_emit    = out_valid && out_ready;

  // MAIN always drives the outputs; it is all-zero whenever no beat is held
  assign {out_pc, out_insn, out_side, out_ret_addr, out_bank} = r_main;

  // State register: flush returns to EMPTY ahead of any handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_EMPTY;
    end else if (flush) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and entry-update selection from the handshake outcome
  always_comb begin
    w_state_nxt = r_state;
    w_main_op   = OP_HOLD;
    w_skid_op   = OP_HOLD;
    case (r_state)
      S_EMPTY: begin
        if (w_acc) begin
          w_state_nxt = S_FULL1;
          w_main_op   = OP_LOAD_IN;
        end else begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL1: begin
        if (w_emit && w_acc) begin
          w_main_op = OP_LOAD_IN;
        end else if (w_emit) begin
          w_state_nxt = S_EMPTY;
          w_main_op   = OP_CLEAR;
        end else if (w_acc) begin
          w_state_nxt = S_FULL2;
          w_skid_op   = OP_LOAD_IN;
        end else begin
          w_state_nxt = S_FULL1;
        end
      end
      S_FULL2: begin
        // in_ready is low here, so an offered beat is never taken
        if (w_emit) begin
          w_state_nxt = S_FULL1;
          w_main_op   = OP_LOAD_SKID;
          w_skid_op   = OP_CLEAR;
        end else begin
          w_state_nxt = S_FULL2;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
        w_main_op   = OP_CLEAR;
        w_skid_op   = OP_CLEAR;
      end
    endcase
  end

  // Entry storage: MAIN and SKID payloads, cleared by reset and flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (flush) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      case (w_main_op)
        OP_LOAD_IN:   r_main <= w_in_entry;
        OP_LOAD_SKID: r_main <= r_skid;
        OP_CLEAR:     r_main <= '0;
        default:      r_main <= r_main;
      endcase
      case (w_skid_op)
        OP_LOAD_IN: r_skid <= w_in_entry;
        OP_CLEAR:   r_skid <= '0;
        default:    r_skid <= r_skid;
      endcase
    end
  end

endmodule
